// File: rtl/sipo_pkg.sv
// Shared types and constants for the SIPO deserializer.
// Defining SIPO_PARITY_EN appends an even-parity bit to every serial frame.
package sipo_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) result = i + 1;
        end
        return result;
    endfunction

`ifdef SIPO_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif

    typedef enum logic {
        SLOT_EMPTY,
        SLOT_HELD
    } slot_state_t;

endpackage

// File: rtl/sipo_word_slot.sv
// One-entry valid/ready holding register for assembled words.
// A load always wins over a drain, which lets a new word replace one leaving in the same cycle.
module sipo_word_slot
    import sipo_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             load_perr,
    input  logic             word_ready,
    output logic             word_valid,
    output logic [WIDTH-1:0] word_out,
    output logic             word_perr
);

    slot_state_t      state, state_next;
    logic [WIDTH-1:0] data_q, data_next;
    logic             perr_q, perr_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= SLOT_EMPTY;
            data_q <= '0;
            perr_q <= 1'b0;
        end else begin
            state  <= state_next;
            data_q <= data_next;
            perr_q <= perr_next;
        end
    end

    always_comb begin
        state_next = state;
        data_next  = data_q;
        perr_next  = perr_q;
        if (clr) begin
            state_next = SLOT_EMPTY;
            data_next  = '0;
            perr_next  = 1'b0;
        end else if (load) begin
            state_next = SLOT_HELD;
            data_next  = load_data;
            perr_next  = load_perr;
        end else if (state == SLOT_HELD && word_ready) begin
            state_next = SLOT_EMPTY;
        end
    end

    assign word_valid = (state == SLOT_HELD);
    assign word_out   = data_q;
    assign word_perr  = perr_q;

endmodule

// File: rtl/sipo_deserializer.sv
// Serial-in, parallel-out deserializer with a one-word output slot (sipo_word_slot).
// SIPO_PARITY_EN: each frame carries a trailing even-parity bit reported on word_perr.
module sipo_deserializer
    import sipo_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int CNT_W     = clog2(WIDTH + 1 + PAR_BITS)
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             bit_valid,
    input  logic             bit_in,
    output logic             bit_ready,
    output logic             word_valid,
    input  logic             word_ready,
    output logic [WIDTH-1:0] word_out,
    output logic             word_perr,
    output logic [CNT_W-1:0] bit_cnt
);

    localparam int              FRAME     = WIDTH + PAR_BITS;
    localparam logic [CNT_W-1:0] FRAME_CNT = CNT_W'(FRAME);
    localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(FRAME - 1);

    logic [WIDTH-1:0] sr, sr_shifted, data_next;
    logic [CNT_W-1:0] cnt;
    logic             full, accept, complete, shift_en, load, load_perr;

    // A counter parked at FRAME means the shift register holds a finished word.
    assign full      = (cnt == FRAME_CNT);
    assign bit_ready = !full;
    assign bit_cnt   = cnt;
    assign accept    = bit_valid && !full;
    assign complete  = accept && (cnt == LAST_CNT);
    assign load      = (complete && (!word_valid || word_ready)) ||
                       (full && word_valid && word_ready);

    generate
        if (MSB_FIRST) begin : g_msb
            assign sr_shifted = {sr[WIDTH-2:0], bit_in};
        end else begin : g_lsb
            assign sr_shifted = {bit_in, sr[WIDTH-1:1]};
        end
    endgenerate

    assign data_next = shift_en ? sr_shifted : sr;

`ifdef SIPO_PARITY_EN
    localparam logic [CNT_W-1:0] DATA_CNT = CNT_W'(WIDTH);

    logic par_q, par_bit;

    // The parity bit stays out of the data; it is kept aside while a word waits in FULL.
    assign shift_en  = accept && (cnt < DATA_CNT);
    assign par_bit   = complete ? bit_in : par_q;
    assign load_perr = (^data_next) ^ par_bit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            par_q <= 1'b0;
        end else if (clr) begin
            par_q <= 1'b0;
        end else if (complete) begin
            par_q <= bit_in;
        end
    end
`else
    assign shift_en  = accept;
    assign load_perr = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sr  <= '0;
            cnt <= '0;
        end else if (clr) begin
            sr  <= '0;
            cnt <= '0;
        end else if (load) begin
            sr  <= '0;
            cnt <= '0;
        end else begin
            sr <= data_next;
            if (accept) cnt <= cnt + CNT_W'(1);
        end
    end

    sipo_word_slot #(
        .WIDTH(WIDTH)
    ) u_slot (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr),
        .load      (load),
        .load_data (data_next),
        .load_perr (load_perr),
        .word_ready(word_ready),
        .word_valid(word_valid),
        .word_out  (word_out),
        .word_perr (word_perr)
    );

endmodule

// File: tb/tb_sipo_deserializer.sv
// Self-checking bench for sipo_deserializer: MSB-first and LSB-first instances share stimulus.
// Honors SIPO_PARITY_EN the same way the design does.
module tb_sipo_deserializer;

`ifdef SIPO_PARITY_EN
    localparam int PAR = 1;
`else
    localparam int PAR = 0;
`endif
    localparam int FRAME = 8 + PAR;
    localparam int CW    = $clog2(8 + 1 + PAR);

    typedef struct packed {
        logic [7:0] msb;
        logic [7:0] lsb;
        logic       perr;
    } word_t;

    logic          clk = 1'b0;
    logic          rst, clr, bit_valid, bit_in, word_ready;
    logic          msb_bit_ready, msb_word_valid, msb_word_perr;
    logic [7:0]    msb_word_out;
    logic [CW-1:0] msb_bit_cnt;
    logic          lsb_bit_ready, lsb_word_valid, lsb_word_perr;
    logic [7:0]    lsb_word_out;
    logic [CW-1:0] lsb_bit_cnt;

    int passed = 0;
    int total  = 0;

    word_t out_q[$];
    bit    cur[$];
    word_t last;

    always #5 clk = ~clk;

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clk(clk), .rst(rst), .clr(clr), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_ready(msb_bit_ready), .word_valid(msb_word_valid), .word_ready(word_ready),
        .word_out(msb_word_out), .word_perr(msb_word_perr), .bit_cnt(msb_bit_cnt)
    );

    sipo_deserializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clk(clk), .rst(rst), .clr(clr), .bit_valid(bit_valid), .bit_in(bit_in),
        .bit_ready(lsb_bit_ready), .word_valid(lsb_word_valid), .word_ready(word_ready),
        .word_out(lsb_word_out), .word_perr(lsb_word_perr), .bit_cnt(lsb_bit_cnt)
    );

    // Reference model: a queue of finished words (slot first) plus the bits of the current frame.
    task automatic model_reset();
        out_q.delete();
        cur.delete();
        last = '0;
    endtask

    task automatic model_edge();
        bit    hs, acc;
        word_t w;
        int    ones;
        if (rst || clr) begin
            model_reset();
            return;
        end
        hs  = (out_q.size() > 0) && word_ready;
        acc = bit_valid && (out_q.size() < 2);
        if (hs) void'(out_q.pop_front());
        if (acc) begin
            cur.push_back(bit_in);
            if (cur.size() == FRAME) begin
                w    = '0;
                ones = 0;
                for (int i = 0; i < 8; i++) begin
                    w.msb[7-i] = cur[i];
                    w.lsb[i]   = cur[i];
                    ones += int'(cur[i]);
                end
                if (PAR == 1) w.perr = ((ones + int'(cur[8])) % 2) != 0;
                out_q.push_back(w);
                cur.delete();
            end
        end
        if (out_q.size() > 0) last = out_q[0];
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Frame bits in transmission order, first bit in the highest used position.
    function automatic logic [15:0] mk_frame(input logic [7:0] d, input bit bad);
        if (PAR == 1) return {7'b0, d, (^d) ^ bad};
        else          return {8'b0, d};
    endfunction

    task automatic applyStimulus(input logic [15:0] bits, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            bit_valid = 1'b1;
            bit_in    = bits[i];
            tick();
        end
        bit_valid = 1'b0;
        bit_in    = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; bit_valid = 1'b0; bit_in = 1'b0; word_ready = 1'b0;
        model_reset();
        repeat (2) tick();
        total++; if (msb_word_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", msb_word_valid); else passed++;
        total++; if (msb_word_out !== 8'h00) $display("[TB] FAIL reset_out: got %h want 00", msb_word_out); else passed++;
        total++; if (lsb_word_out !== 8'h00) $display("[TB] FAIL reset_out_lsb: got %h want 00", lsb_word_out); else passed++;
        total++; if (msb_bit_cnt !== '0) $display("[TB] FAIL reset_cnt: got %0d want 0", msb_bit_cnt); else passed++;
        total++; if (msb_word_perr !== 1'b0) $display("[TB] FAIL reset_perr: got %b want 0", msb_word_perr); else passed++;
        rst = 1'b0;
        tick();
        total++; if (msb_bit_ready !== 1'b1) $display("[TB] FAIL reset_ready: got %b want 1", msb_bit_ready); else passed++;
    endtask

    task automatic test_msb_first();
        logic [15:0] f;
        word_ready = 1'b1;
        f = mk_frame(8'hA5, 1'b0);
        applyStimulus(f >> 1, FRAME - 1);
        total++; if (msb_word_valid !== 1'b0) $display("[TB] FAIL msb_early_valid: got %b want 0", msb_word_valid); else passed++;
        total++; if (msb_bit_cnt !== CW'(FRAME - 1)) $display("[TB] FAIL msb_partial_cnt: got %0d want %0d", msb_bit_cnt, FRAME - 1); else passed++;
        applyStimulus(f, 1);
        total++; if (msb_word_valid !== 1'b1) $display("[TB] FAIL msb_valid: got %b want 1", msb_word_valid); else passed++;
        total++; if (msb_word_out !== 8'hA5) $display("[TB] FAIL msb_out: got %h want a5", msb_word_out); else passed++;
        total++; if (lsb_word_out !== 8'hA5) $display("[TB] FAIL msb_lsb_out: got %h want a5", lsb_word_out); else passed++;
        total++; if (msb_bit_cnt !== '0) $display("[TB] FAIL msb_cnt: got %0d want 0", msb_bit_cnt); else passed++;
        tick();
        total++; if (msb_word_valid !== 1'b0) $display("[TB] FAIL msb_one_cycle: got %b want 0", msb_word_valid); else passed++;
    endtask

    task automatic test_lsb_first();
        word_ready = 1'b1;
        applyStimulus(mk_frame(8'hF0, 1'b0), FRAME);
        total++; if (lsb_word_out !== 8'h0F) $display("[TB] FAIL lsb_out: got %h want 0f", lsb_word_out); else passed++;
        total++; if (msb_word_out !== 8'hF0) $display("[TB] FAIL lsb_msb_out: got %h want f0", msb_word_out); else passed++;
        total++; if (lsb_word_valid !== 1'b1) $display("[TB] FAIL lsb_valid: got %b want 1", lsb_word_valid); else passed++;
        tick();
    endtask

    task automatic test_backpressure();
        word_ready = 1'b0;
        applyStimulus(mk_frame(8'h11, 1'b0), FRAME);
        total++; if (msb_word_out !== 8'h11) $display("[TB] FAIL bp_first: got %h want 11", msb_word_out); else passed++;
        applyStimulus(mk_frame(8'h22, 1'b0), FRAME);
        total++; if (msb_bit_ready !== 1'b0) $display("[TB] FAIL bp_ready: got %b want 0", msb_bit_ready); else passed++;
        total++; if (msb_bit_cnt !== CW'(FRAME)) $display("[TB] FAIL bp_cnt: got %0d want %0d", msb_bit_cnt, FRAME); else passed++;
        bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        bit_valid = 1'b0;
        total++; if (msb_bit_cnt !== CW'(FRAME)) $display("[TB] FAIL bp_refused: got %0d want %0d", msb_bit_cnt, FRAME); else passed++;
        total++; if (msb_word_out !== 8'h11 || msb_word_valid !== 1'b1) $display("[TB] FAIL bp_stable: got %h/%b want 11/1", msb_word_out, msb_word_valid); else passed++;
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        total++; if (msb_word_out !== 8'h22) $display("[TB] FAIL bp_second: got %h want 22", msb_word_out); else passed++;
        total++; if (msb_word_valid !== 1'b1) $display("[TB] FAIL bp_valid_kept: got %b want 1", msb_word_valid); else passed++;
        total++; if (msb_bit_ready !== 1'b1 || msb_bit_cnt !== '0) $display("[TB] FAIL bp_resume: got %b/%0d want 1/0", msb_bit_ready, msb_bit_cnt); else passed++;
        word_ready = 1'b1;
        tick();
        total++; if (msb_word_valid !== 1'b0) $display("[TB] FAIL bp_drain: got %b want 0", msb_word_valid); else passed++;
    endtask

    task automatic test_async_reset();
        word_ready = 1'b1;
        applyStimulus(16'h0016, 5);
        total++; if (msb_bit_cnt !== CW'(5)) $display("[TB] FAIL ar_partial: got %0d want 5", msb_bit_cnt); else passed++;
        #3;
        rst = 1'b1;
        model_reset();
        #1;
        total++; if (msb_bit_cnt !== '0 || msb_word_valid !== 1'b0 || msb_word_out !== 8'h00) $display("[TB] FAIL ar_immediate: got cnt %0d valid %b out %h want 0/0/00", msb_bit_cnt, msb_word_valid, msb_word_out); else passed++;
        tick();
        rst = 1'b0;
        applyStimulus(mk_frame(8'h3C, 1'b0), FRAME);
        total++; if (msb_word_out !== 8'h3C || msb_word_valid !== 1'b1) $display("[TB] FAIL ar_fresh: got %h/%b want 3c/1", msb_word_out, msb_word_valid); else passed++;
        tick();
    endtask

    task automatic test_clr_priority();
        word_ready = 1'b0;
        applyStimulus(mk_frame(8'h5A, 1'b0), FRAME);
        applyStimulus(mk_frame(8'hC3, 1'b0), FRAME);
        total++; if (msb_bit_ready !== 1'b0) $display("[TB] FAIL clr_full: got %b want 0", msb_bit_ready); else passed++;
        clr = 1'b1; word_ready = 1'b1; bit_valid = 1'b1; bit_in = 1'b1;
        tick();
        clr = 1'b0; word_ready = 1'b0; bit_valid = 1'b0; bit_in = 1'b0;
        total++; if (msb_word_valid !== 1'b0) $display("[TB] FAIL clr_valid: got %b want 0", msb_word_valid); else passed++;
        total++; if (msb_bit_cnt !== '0 || msb_bit_ready !== 1'b1) $display("[TB] FAIL clr_cnt: got %0d/%b want 0/1", msb_bit_cnt, msb_bit_ready); else passed++;
        total++; if (msb_word_out !== 8'h00) $display("[TB] FAIL clr_out: got %h want 00", msb_word_out); else passed++;
    endtask

    task automatic test_parity();
        logic [15:0] f;
        word_ready = 1'b1;
`ifdef SIPO_PARITY_EN
        applyStimulus(mk_frame(8'hA5, 1'b0), FRAME);
        total++; if (msb_word_perr !== 1'b0 || msb_word_out !== 8'hA5) $display("[TB] FAIL par_good: got %b/%h want 0/a5", msb_word_perr, msb_word_out); else passed++;
        tick();
        f = mk_frame(8'hA5, 1'b1);
        applyStimulus(f >> 1, 8);
        total++; if (msb_word_valid !== 1'b0 || msb_bit_cnt !== CW'(8)) $display("[TB] FAIL par_nine: got %b/%0d want 0/8", msb_word_valid, msb_bit_cnt); else passed++;
        applyStimulus(f, 1);
        total++; if (msb_word_valid !== 1'b1 || msb_word_perr !== 1'b1) $display("[TB] FAIL par_bad: got %b/%b want 1/1", msb_word_valid, msb_word_perr); else passed++;
        total++; if (msb_word_out !== 8'hA5 || msb_bit_cnt !== '0) $display("[TB] FAIL par_data: got %h/%0d want a5/0", msb_word_out, msb_bit_cnt); else passed++;
`else
        f = mk_frame(8'hA7, 1'b0);
        applyStimulus(f, FRAME);
        total++; if (msb_word_perr !== 1'b0 || lsb_word_perr !== 1'b0) $display("[TB] FAIL perr_tied: got %b/%b want 0/0", msb_word_perr, lsb_word_perr); else passed++;
        total++; if (msb_word_out !== 8'hA7) $display("[TB] FAIL perr_data: got %h want a7", msb_word_out); else passed++;
`endif
        tick();
    endtask

    task automatic test_random();
        logic [CW-1:0] exp_cnt;
        bit            exp_valid, exp_ready;
        for (int c = 0; c < 400; c++) begin
            bit_valid  = ($urandom_range(0, 3) != 0);
            bit_in     = 1'($urandom);
            word_ready = ($urandom_range(0, 2) != 0) ? 1'($urandom) : 1'b0;
            clr        = ($urandom_range(0, 49) == 0);
            tick();
            exp_valid = (out_q.size() > 0);
            exp_ready = (out_q.size() < 2);
            exp_cnt   = (out_q.size() == 2) ? CW'(FRAME) : CW'(cur.size());
            total++; if (msb_word_valid !== exp_valid || lsb_word_valid !== exp_valid) $display("[TB] FAIL rnd_valid c%0d: got %b/%b want %b", c, msb_word_valid, lsb_word_valid, exp_valid); else passed++;
            total++; if (msb_word_out !== last.msb) $display("[TB] FAIL rnd_out_msb c%0d: got %h want %h", c, msb_word_out, last.msb); else passed++;
            total++; if (lsb_word_out !== last.lsb) $display("[TB] FAIL rnd_out_lsb c%0d: got %h want %h", c, lsb_word_out, last.lsb); else passed++;
            total++; if (msb_word_perr !== last.perr) $display("[TB] FAIL rnd_perr c%0d: got %b want %b", c, msb_word_perr, last.perr); else passed++;
            total++; if (msb_bit_cnt !== exp_cnt || lsb_bit_cnt !== exp_cnt) $display("[TB] FAIL rnd_cnt c%0d: got %0d/%0d want %0d", c, msb_bit_cnt, lsb_bit_cnt, exp_cnt); else passed++;
            total++; if (msb_bit_ready !== exp_ready || lsb_bit_ready !== exp_ready) $display("[TB] FAIL rnd_ready c%0d: got %b/%b want %b", c, msb_bit_ready, lsb_bit_ready, exp_ready); else passed++;
        end
        clr = 1'b0; bit_valid = 1'b0; word_ready = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        test_reset();
        test_msb_first();
        test_lsb_first();
        test_backpressure();
        test_async_reset();
        test_clr_priority();
        test_parity();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
